// File: rtl/alu_pkg.sv
// Shared definitions for the arithmetic command front-end: function codes,
// issue FSM states and default widths.
package alu_pkg;

   localparam int ALU_IN_WIDTH   = 16;
   localparam int ALU_OUT_WIDTH  = 2 * ALU_IN_WIDTH;
   localparam int ALU_FIFO_DEPTH = 4;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_MUL = 2'd2;
   localparam logic [1:0] ALU_DIV = 2'd3;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } issue_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO holding {fun, a, b}; pointers carry an extra wrap
// bit so full and empty are distinguished without a separate counter.
module alu_cmd_fifo
   import alu_pkg::*;
#(
   parameter int WIDTH      = 2 + 2 * ALU_IN_WIDTH,
   parameter int FIFO_DEPTH = ALU_FIFO_DEPTH
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [AW:0]      wr_ptr_q, wr_ptr_d;
   logic [AW:0]      rd_ptr_q, rd_ptr_d;
   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];

   always_comb begin
      full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      empty    = (wr_ptr_q == rd_ptr_q);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (push && !full) begin
         wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (pop && !empty) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
   end

   assign dout = mem_q[rd_ptr_q[AW-1:0]];

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge CLK) begin
      if (push && !full) begin
         mem_q[wr_ptr_q[AW-1:0]] <= din;
      end
   end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Command front-end for the 16-bit arithmetic unit: FIFO, one-in-flight issue
// FSM and held response. Define ALU_ISSUE_DIVZ_CHK_EN to trap divide-by-zero.
module alu_cmd_issuer
   import alu_pkg::*;
#(
   parameter int IN_WIDTH        = ALU_IN_WIDTH,
   parameter int ARITH_OUT_WIDTH = 2 * IN_WIDTH,
   parameter int FIFO_DEPTH      = ALU_FIFO_DEPTH
) (
   input  logic                              CLK,
   input  logic                              RST,
   input  logic                              cmd_valid,
   output logic                              cmd_ready,
   input  logic [1:0]                        cmd_fun,
   input  logic signed [IN_WIDTH-1:0]        cmd_a,
   input  logic signed [IN_WIDTH-1:0]        cmd_b,
   output logic signed [IN_WIDTH-1:0]        A,
   output logic signed [IN_WIDTH-1:0]        B,
   output logic [1:0]                        ALU_FUN,
   output logic                              Arith_EN,
   input  logic signed [ARITH_OUT_WIDTH-1:0] Arith_OUT,
   output logic                              res_valid,
   input  logic                              res_ready,
   output logic signed [ARITH_OUT_WIDTH-1:0] res_data,
   output logic [1:0]                        res_fun,
   output logic                              res_err
);

   localparam int ENTRY_W = 2 + 2 * IN_WIDTH;

   logic                 push, pop, full, empty, start, trap;
   logic [ENTRY_W-1:0]   head;
   logic [1:0]           head_fun;
   logic signed [IN_WIDTH-1:0] head_a, head_b;

   issue_state_t state_q, state_d;
   logic signed [IN_WIDTH-1:0]        a_q, a_d, b_q, b_d;
   logic [1:0]                        fun_q, fun_d, res_fun_q, res_fun_d;
   logic                              en_q, en_d, res_valid_q, res_valid_d;
   logic signed [ARITH_OUT_WIDTH-1:0] res_data_q, res_data_d;
`ifdef ALU_ISSUE_DIVZ_CHK_EN
   logic                              res_err_q, res_err_d;
`endif

   assign push      = cmd_valid && !full;
   assign cmd_ready = !full;
   assign {head_fun, head_a, head_b} = head;

   alu_cmd_fifo #(
      .WIDTH      (ENTRY_W),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (push),
      .din   ({cmd_fun, cmd_a, cmd_b}),
      .pop   (pop),
      .dout  (head),
      .full  (full),
      .empty (empty)
   );

`ifdef ALU_ISSUE_DIVZ_CHK_EN
   assign trap = (head_fun == ALU_DIV) && (head_b == '0);
`else
   assign trap = 1'b0;
`endif

   always_comb begin
      state_d     = state_q;
      a_d         = a_q;
      b_d         = b_q;
      fun_d       = fun_q;
      en_d        = 1'b0;
      res_valid_d = res_valid_q;
      res_data_d  = res_data_q;
      res_fun_d   = res_fun_q;
`ifdef ALU_ISSUE_DIVZ_CHK_EN
      res_err_d   = res_err_q;
`endif
      start       = 1'b0;
      pop         = 1'b0;

      case (state_q)
         IDLE: begin
            start = !empty;
         end
         ISSUE: begin
            state_d = WAIT;
         end
         WAIT: begin
            res_data_d  = Arith_OUT;
            res_fun_d   = fun_q;
            res_valid_d = 1'b1;
`ifdef ALU_ISSUE_DIVZ_CHK_EN
            res_err_d   = 1'b0;
`endif
            state_d     = RESP;
         end
         RESP: begin
            // A trapped command enters RESP with the response staged but not yet valid.
            if (!res_valid_q) begin
               res_valid_d = 1'b1;
            end else if (res_ready) begin
               res_valid_d = 1'b0;
               if (!empty) begin
                  start = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      if (start) begin
         pop = 1'b1;
         if (trap) begin
            res_data_d = '0;
            res_fun_d  = ALU_DIV;
`ifdef ALU_ISSUE_DIVZ_CHK_EN
            res_err_d  = 1'b1;
`endif
            state_d    = RESP;
         end else begin
            a_d     = head_a;
            b_d     = head_b;
            fun_d   = head_fun;
            en_d    = 1'b1;
            state_d = ISSUE;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q     <= IDLE;
         a_q         <= '0;
         b_q         <= '0;
         fun_q       <= '0;
         en_q        <= 1'b0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
         res_fun_q   <= '0;
`ifdef ALU_ISSUE_DIVZ_CHK_EN
         res_err_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         a_q         <= a_d;
         b_q         <= b_d;
         fun_q       <= fun_d;
         en_q        <= en_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
         res_fun_q   <= res_fun_d;
`ifdef ALU_ISSUE_DIVZ_CHK_EN
         res_err_q   <= res_err_d;
`endif
      end
   end

   assign A         = a_q;
   assign B         = b_q;
   assign ALU_FUN   = fun_q;
   assign Arith_EN  = en_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;
   assign res_fun   = res_fun_q;
`ifdef ALU_ISSUE_DIVZ_CHK_EN
   assign res_err   = res_err_q;
`else
   assign res_err   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Bench for alu_cmd_issuer: arithmetic-unit model, queue-based reference of
// issued commands and responses, directed scenarios plus randomized traffic.
module tb_alu_cmd_issuer;
   import alu_pkg::*;

   localparam int W  = 16;
   localparam int OW = 32;
`ifdef ALU_ISSUE_DIVZ_CHK_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic CLK = 1'b0;
   logic RST = 1'b0;
   logic cmd_valid = 1'b0;
   logic cmd_ready;
   logic [1:0] cmd_fun = 2'd0;
   logic signed [W-1:0] cmd_a = '0, cmd_b = '0;
   logic signed [W-1:0] A, B;
   logic [1:0] ALU_FUN;
   logic Arith_EN;
   logic signed [OW-1:0] Arith_OUT = '0;
   logic res_valid;
   logic res_ready = 1'b0;
   logic signed [OW-1:0] res_data;
   logic [1:0] res_fun;
   logic res_err;

   alu_cmd_issuer dut (
      .CLK(CLK), .RST(RST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_fun(cmd_fun), .cmd_a(cmd_a), .cmd_b(cmd_b), .A(A), .B(B),
      .ALU_FUN(ALU_FUN), .Arith_EN(Arith_EN), .Arith_OUT(Arith_OUT),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_fun(res_fun), .res_err(res_err)
   );

   always #5 CLK = ~CLK;

   int n_vec = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic logic signed [OW-1:0] alu_f(input logic [1:0] f, input logic signed [W-1:0] a,
                                                  input logic signed [W-1:0] b);
      logic signed [OW-1:0] ea, eb;
      ea = a;
      eb = b;
      case (f)
         2'd0:    return ea + eb;
         2'd1:    return ea - eb;
         2'd2:    return ea * eb;
         default: return (eb == 0) ? '0 : ea / eb;
      endcase
   endfunction

   // Arithmetic unit: registers its result on the edge closing the enable cycle.
   always @(posedge CLK) begin
      if (Arith_EN) Arith_OUT <= alu_f(ALU_FUN, A, B);
   end

   typedef struct packed {logic [1:0] f; logic signed [W-1:0] a; logic signed [W-1:0] b;} cmd_t;
   typedef struct packed {logic signed [OW-1:0] d; logic [1:0] f; logic e;} rsp_t;

   cmd_t iss_q[$];
   rsp_t rsp_q[$];
   rsp_t log_q[$];
   int   en_cnt = 0;
   bit   prev_hold = 1'b0, prev_en = 1'b0;
   logic signed [OW-1:0] prev_d = '0;
   logic [1:0] prev_f = '0;
   logic prev_e = 1'b0;

   always @(negedge CLK) begin
      cmd_t c;
      rsp_t r;
      if (!RST) begin
         iss_q.delete();
         rsp_q.delete();
         prev_hold = 1'b0;
         prev_en   = 1'b0;
      end else begin
         if (Arith_EN) begin
            en_cnt++;
            chk("en_single_cycle", prev_en, 0);
            chk("en_while_resp", res_valid, 0);
            if (iss_q.size() == 0) chk("issue_unexpected", 1, 0);
            else begin
               c = iss_q.pop_front();
               chk("issue_cmd", {ALU_FUN, A, B}, c);
            end
         end
         if (prev_hold) begin
            chk("hold_valid", res_valid, 1);
            chk("hold_data", res_data, prev_d);
            chk("hold_fun", res_fun, prev_f);
            chk("hold_err", res_err, prev_e);
         end
         if (res_valid && res_ready) begin
            if (rsp_q.size() == 0) chk("resp_unexpected", 1, 0);
            else begin
               r = rsp_q.pop_front();
               chk("resp_data", res_data, r.d);
               chk("resp_fun", res_fun, r.f);
               chk("resp_err", res_err, r.e);
            end
            log_q.push_back({res_data, res_fun, res_err});
         end
         if (cmd_valid && cmd_ready) begin
            c = {cmd_fun, cmd_a, cmd_b};
            if (TRAP && cmd_fun == 2'd3 && cmd_b == 0) rsp_q.push_back({32'sd0, 2'd3, 1'b1});
            else begin
               iss_q.push_back(c);
               rsp_q.push_back({alu_f(cmd_fun, cmd_a, cmd_b), cmd_fun, 1'b0});
            end
         end
         prev_hold = res_valid && !res_ready;
         prev_d    = res_data;
         prev_f    = res_fun;
         prev_e    = res_err;
         prev_en   = Arith_EN;
      end
   end

   // Call just after a rising edge; returns just after the accepting edge.
   task automatic push(input logic [1:0] f, input int a, input int b);
      bit ok;
      ok = 1'b0;
      cmd_fun = f;
      cmd_a = a[15:0];
      cmd_b = b[15:0];
      cmd_valid = 1'b1;
      for (int k = 0; k < 60; k++) begin
         @(negedge CLK);
         if (cmd_ready) begin
            ok = 1'b1;
            break;
         end
      end
      chk("push_accept", ok, 1);
      @(posedge CLK);
      #1 cmd_valid = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int c0, L;
      bit ok, seen;
      logic [31:0] t;

      // Reset state
      repeat (2) @(negedge CLK);
      chk("rst_A", A, 0);
      chk("rst_B", B, 0);
      chk("rst_fun", ALU_FUN, 0);
      chk("rst_en", Arith_EN, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res_data", res_data, 0);
      chk("rst_res_fun", res_fun, 0);
      chk("rst_res_err", res_err, 0);
      chk("rst_cmd_ready", cmd_ready, 1);
      @(posedge CLK);
      #1 RST = 1'b1;
      res_ready = 1'b1;
      @(posedge CLK);
      #1;

      // Single add: issue one cycle after acceptance, result three edges after
      push(2'd0, 5, 7);
      @(negedge CLK); chk("add_en_c0", Arith_EN, 0);
      @(negedge CLK); chk("add_en_c1", Arith_EN, 1);
      @(negedge CLK); chk("add_en_c2", Arith_EN, 0); chk("add_valid_c2", res_valid, 0);
      @(negedge CLK); chk("add_valid_c3", res_valid, 1);
      chk("add_data", res_data, 12); chk("add_fun", res_fun, 0);
      repeat (3) @(posedge CLK);
      #1;

      // Backpressure: response held for 5 cycles without further issue
      res_ready = 1'b0;
      push(2'd0, 1, 2);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         if (res_valid) begin ok = 1'b1; break; end
      end
      chk("bp_wait_valid", ok, 1);
      c0 = en_cnt;
      repeat (5) @(negedge CLK);
      chk("bp_no_issue", en_cnt - c0, 0);
      chk("bp_valid", res_valid, 1);
      chk("bp_data", res_data, 3);
      chk("bp_fun", res_fun, 0);
      @(posedge CLK);
      #1;

      // Four queued commands fill the FIFO, then drain in order
      push(2'd1, 3, 10);
      push(2'd2, -4, 6);
      push(2'd3, 100, 7);
      push(2'd0, 32767, 1);
      @(negedge CLK); chk("fifo_full_ready", cmd_ready, 0);
      L = log_q.size();
      @(posedge CLK);
      #1 res_ready = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
         @(negedge CLK);
         if (log_q.size() >= L + 5) begin ok = 1'b1; break; end
      end
      chk("drain4_done", ok, 1);
      if (ok) begin
         chk("order_0", log_q[L].d, 3);
         chk("order_1", log_q[L+1].d, -7);
         chk("order_2", log_q[L+2].d, -24);
         chk("order_3", log_q[L+3].d, 14);
         chk("order_4", log_q[L+4].d, 32768);
      end
      @(posedge CLK);
      #1;

      // Divide by zero
      c0 = en_cnt;
      L = log_q.size();
      push(2'd3, 9, 0);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         if (log_q.size() >= L + 1) begin ok = 1'b1; break; end
      end
      chk("divz_resp", ok, 1);
      if (ok) begin
         chk("divz_fun", log_q[L].f, 3);
`ifdef ALU_ISSUE_DIVZ_CHK_EN
         chk("divz_en_pulses", en_cnt - c0, 0);
         chk("divz_err", log_q[L].e, 1);
         chk("divz_data", log_q[L].d, 0);
`else
         chk("divz_en_pulses", en_cnt - c0, 1);
         chk("divz_err", log_q[L].e, 0);
`endif
      end
      @(posedge CLK);
      #1;

      // Randomized traffic against the reference queues
      for (int i = 0; i < 400; i++) begin
         t = $urandom;
         cmd_fun   = t[17:16];
         cmd_a     = t[15:0];
         t = $urandom;
         cmd_b     = ($urandom_range(0, 7) == 0) ? 16'sd0 : $signed(t[15:0]);
         cmd_valid = ($urandom_range(0, 2) != 0);
         res_ready = ($urandom_range(0, 3) != 0);
         @(posedge CLK);
         #1;
      end
      cmd_valid = 1'b0;
      res_ready = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 200; k++) begin
         @(negedge CLK);
         if (rsp_q.size() == 0 && iss_q.size() == 0 && !res_valid) begin ok = 1'b1; break; end
      end
      chk("random_drain", ok, 1);
      @(posedge CLK);
      #1;

      // Reset asserted while a command is in ISSUE with two more queued
      res_ready = 1'b0;
      push(2'd0, 1, 1);
      push(2'd1, 2, 2);
      push(2'd2, 3, 3);
      push(2'd0, 4, 4);
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         if (res_valid) begin ok = 1'b1; break; end
      end
      chk("rst_setup_valid", ok, 1);
      @(posedge CLK);
      #1 res_ready = 1'b1;
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         if (Arith_EN) begin ok = 1'b1; break; end
      end
      chk("rst_setup_issue", ok, 1);
      #1 RST = 1'b0;
      #1;
      chk("midrst_A", A, 0);
      chk("midrst_B", B, 0);
      chk("midrst_fun", ALU_FUN, 0);
      chk("midrst_en", Arith_EN, 0);
      chk("midrst_res_valid", res_valid, 0);
      chk("midrst_res_data", res_data, 0);
      chk("midrst_res_fun", res_fun, 0);
      chk("midrst_res_err", res_err, 0);
      chk("midrst_cmd_ready", cmd_ready, 1);
      @(posedge CLK);
      @(posedge CLK);
      #1 RST = 1'b1;
      c0 = en_cnt;
      L = log_q.size();
      seen = 1'b0;
      repeat (20) begin
         @(negedge CLK);
         if (res_valid) seen = 1'b1;
      end
      chk("postrst_no_issue", en_cnt - c0, 0);
      chk("postrst_no_valid", seen, 0);
      chk("postrst_no_resp", log_q.size() - L, 0);
      chk("postrst_cmd_ready", cmd_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command front-end placed directly upstream of the 16-bit arithmetic unit. It accepts arithmetic commands over a valid/ready handshake and buffers them in a small FIFO. It issues them one at a time to the arithmetic unit as a single-cycle enable pulse with registered operands, then captures the registered result into a held response with its own valid/ready handshake. Optionally, it traps divide-by-zero before issue.

## Interface
- IN_WIDTH, 16, operand width; matches the arithmetic unit.
- ARITH_OUT_WIDTH, 2*IN_WIDTH, result width; matches the arithmetic unit.
- FIFO_DEPTH, 4, command FIFO entries; power of two, ≥2.

- CLK  in  1  single clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  FIFO not full.
- cmd_fun  in  2  0 add, 1 sub, 2 mul, 3 div.
- cmd_a  in  IN_WIDTH signed  operand A.
- cmd_b  in  IN_WIDTH signed  operand B.
- A  out  IN_WIDTH signed  registered operand to the arithmetic unit.
- B  out  IN_WIDTH signed  registered operand to the arithmetic unit.
- ALU_FUN  out  2  registered function select.
- Arith_EN  out  1  one-cycle issue pulse.
- Arith_OUT  in  ARITH_OUT_WIDTH signed  result from the arithmetic unit.
- res_valid  out  1  response held.
- res_ready  in  1  consumer accepts the response.
- res_data  out  ARITH_OUT_WIDTH signed  captured result.
- res_fun  out  2  function code of the response.
- res_err  out  1  divide-by-zero trapped.

## Operation
- Push: a command is written on an edge where cmd_valid && cmd_ready. cmd_ready = !full. There is no same-cycle pass-through: when full, cmd_ready = 0 even if a pop occurs in the same cycle.
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
  - IDLE, FIFO non-empty:
    - Pop the head.
    - Load A, B and ALU_FUN.
    - Set Arith_EN = 1.
    - Go to ISSUE.
  - IDLE, FIFO empty: stay in IDLE.
  - ISSUE: Arith_EN is high for exactly this cycle. The arithmetic unit registers the result at this cycle's closing edge. Go to WAIT with Arith_EN = 0.
  - WAIT:
    - res_data <= Arith_OUT.
    - res_fun <= ALU_FUN.
    - res_err <= 0.
    - res_valid <= 1.
    - Go to RESP.
  - RESP: hold every res_* output stable until res_ready.
    - On res_ready with FIFO non-empty: clear res_valid, pop and load the next command, and go directly to ISSUE.
    - On res_ready with FIFO empty: clear res_valid and go to IDLE.
- Only one command is in flight at a time. A, B and ALU_FUN hold their last issued values while idle.
- The arithmetic unit's Arith_Flag and Carry_Out are not consumed. Completion is by fixed latency only.
- Reset, including reset asserted mid-operation:
  - The FIFO is emptied and any in-flight command is dropped.
  - The FSM goes to IDLE.
  - A, B, ALU_FUN, Arith_EN, res_valid, res_data, res_fun and res_err are 0.
  - cmd_ready is 1 (FIFO empty).

## Timing
- Command accepted at edge e0 into an empty FIFO with the FSM in IDLE:
  - The pop occurs at e1 and Arith_EN is high in cycle e1–e2.
  - The result is captured at e3, and res_valid is high from e3.
- Back-to-back throughput is one command per 3 cycles when res_ready is held at 1.
- A response is held for as long as res_ready is low. The FIFO keeps accepting commands until full.

## Configuration
- ALU_ISSUE_DIVZ_CHK_EN defined: when IDLE or RESP pops a command with fun = 3 and b = 0:
  - No issue is made and Arith_EN stays 0.
  - The next state is RESP.
  - res_data = 0, res_fun = 3, res_err = 1.
  - res_valid rises at the edge following the pop, one cycle after the pop edge.
- ALU_ISSUE_DIVZ_CHK_EN undefined: divide-by-zero is issued normally and the result is whatever Arith_OUT returns. res_err is tied to 0.

## Structure
- Shared package alu_pkg holds:
  - the function encodings ALU_ADD = 0, ALU_SUB = 1, ALU_MUL = 2, ALU_DIV = 3;
  - the FSM state enum (IDLE, ISSUE, WAIT, RESP);
  - the default widths.
- Sub-module alu_cmd_fifo is a synchronous FIFO with:
  - entries of {fun, a, b}, parameter FIFO_DEPTH;
  - outputs full and empty;
  - pointers one bit wider than the address for wrap detection;
  - the same CLK and RST.

## Test plan
- Single add, a = 5, b = 7, res_ready = 1: Arith_EN is high for exactly 1 cycle and res_valid rises 3 cycles after acceptance. Using a behavioural model of the arithmetic unit, res_data = 12 and res_fun = 0.
- Four commands pushed back-to-back (sub 3-10, mul -4·6, div 100/7, add 32767+1) with res_ready = 0:
  - cmd_ready drops after the 4th push (FIFO_DEPTH = 4).
  - Responses are delivered in order as -7, -24, 14, 32768 once res_ready is released.
- Backpressure: res_ready is held low 5 cycles with a response pending. res_data, res_fun and res_valid stay stable, and no further Arith_EN pulse occurs.
- Div 9/0 with ALU_ISSUE_DIVZ_CHK_EN defined: no Arith_EN pulse, res_err = 1, res_data = 0. With the macro undefined: one Arith_EN pulse and res_err = 0.
- RST asserted during the ISSUE state with 2 queued commands: all outputs are 0 immediately, cmd_ready = 1, and after release there is no response and no Arith_EN pulse.
